interrupt_priority_controller: RTL and testbench
================================================

# interrupt_priority_controller

Parametrised interrupt controller for the Processor12 family. It synchronises `LINES` external request lines, latches pending requests per line (edge or level, chosen per line at elaboration) and applies a run-time mask. It reports the lowest-index unmasked pending line to the core as `next_interrupt`. It also accepts software create/dismiss/mask commands over the core's 12-bit write path, and counts edge requests lost while already pending.

## Interface
- `LINES`, 24: number of request lines; 1..(2^(DATA_WIDTH-1))-1.
- `DATA_WIDTH`, 12: width of `data_in` / `next_interrupt`.
- `SYNC_STAGES`, 2: synchroniser depth on `irq`; ≥1.
- `EDGE_LINES`, all ones (`LINES` bits): bit i=1 → line i rising-edge triggered, 0 → level.
- `MASK_INIT`, 0 (`LINES` bits): mask value after reset; 1 = masked.
- `clk`  in  1  sole clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `irq`  in  LINES  asynchronous request lines.
- `create`  in  1  set pending for line `data_in`.
- `dismiss`  in  1  clear pending for line `data_in`.
- `mask_write`  in  1  `data_in[DATA_WIDTH-1]` = new mask bit for line `data_in[DATA_WIDTH-2:0]`.
- `data_in`  in  DATA_WIDTH  line index / mask command.
- `next_interrupt`  out  DATA_WIDTH  registered; lowest unmasked pending index, else NONE (all ones, 12'o7777 by default).
- `irq_active`  out  1  registered; `next_interrupt != NONE`.
- `lost_count`  out  8  saturating count of dropped edge requests.

## Operation
- Synchroniser: `irq` passes through `SYNC_STAGES` flops; `prev` flop holds the previous synced value.
- Edge line i: `synced & ~prev` sets `pending[i]`. Level line i: `synced` high sets `pending[i]` every cycle; dropping the level does not clear it.
- `create` with index < LINES sets that bit; index ≥ LINES ignored.
- `dismiss` with index < LINES clears that bit; index ≥ LINES ignored. A level line still high re-pends on the next cycle.
- Same cycle, same line, hardware set + `dismiss`: set wins; bit stays 1.
- `create` and `dismiss` together: `dismiss` executes, `create` ignored.
- `mask_write`: index ≥ LINES ignored. Takes effect for the next registered `next_interrupt`. Masked lines keep latching pending.
- `mask_write` may coincide with `create`/`dismiss`; all three act on the same `data_in` index field.
- Priority: lowest index wins. `next_interrupt` = index zero-extended to `DATA_WIDTH`.
- Lost request: a hardware edge on a line already pending and not dismissed that cycle increments `lost_count`; it holds at 255.

## Timing
- Reset (sync, `rst`=1 at a rising edge): sync flops, `prev`, `pending` = 0; mask = `MASK_INIT`; `next_interrupt` = NONE; `irq_active` = 0; `lost_count` = 0.
- An `irq` held high through reset is seen as a rising edge after release: one request is latched.
- `irq` rise first sampled at edge E0: `pending` set at E0+SYNC_STAGES; `next_interrupt` valid after E0+SYNC_STAGES+1 (E0+3 by default).
- `create`/`dismiss`/`mask_write` sampled at E0: pending/mask update at E0; `next_interrupt` reflects the change after E0+1.
- No handshake: commands are single-cycle strobes, accepted every cycle. Back-to-back commands are legal.
- `rst` asserted mid-operation discards all pending state and any in-flight synchroniser contents on that edge.

## Structure
- Package `intc_pkg`:
  - `IDX_W = $clog2(LINES)`.
  - function `none_code(DATA_WIDTH)`.
  - lowest-set-bit priority-encode function.
- Sub-module `irq_synchronizer #(WIDTH, STAGES)`: the flop chain plus `prev` register, outputs `synced` and `rise`.
- Top level holds pending/mask/lost logic and the output register. Expected 150–250 lines total.

## Test plan
- Reset, then pulse `irq[5]` for 3 cycles → `next_interrupt` = 12'o0005 exactly 3 edges after first sample; `irq_active`=1.
- Pending {3,9}: `dismiss` data_in=3 → next_interrupt 12'o0011 one cycle later; `dismiss` 9 → 12'o7777, `irq_active`=0.
- `mask_write` data_in=12'o4002 (mask line 2), then `create` 2 → stays 12'o7777. Then `mask_write` 12'o0002 → 12'o0002 next cycle.
- Level line 0 (`EDGE_LINES[0]`=0) held high: `dismiss` 0 → next_interrupt stays 12'o0000. Release `irq[0]` then `dismiss` → 12'o7777.
- Line 7 already pending, 300 further edges without dismiss → `lost_count` = 255 (saturated). `create` 12'o0030 (24 ≥ LINES) → no change.
- `rst` asserted during a pending burst → all outputs return to reset values at that edge; no stale interrupt after release.

Source files
------------

// File: rtl/intc_pkg.sv
// intc_pkg: shared definitions for interrupt_priority_controller.
//   MAX_LINES / MAX_IDX_W - upper bound on request lines (DATA_WIDTH 12 allows 2047)
//   prio_t                - result of the lowest-set-bit priority encoder
//   idx_width()           - index width for a given line count ($clog2, minimum 1)
//   none_code()           - all-ones "no interrupt" code for a data width
//   lowest_set()          - lowest-index set bit of a request vector
package intc_pkg;

  localparam int unsigned MAX_LINES = 2048;
  localparam int unsigned MAX_IDX_W = 11;

  typedef struct packed {
    logic                 found;
    logic [MAX_IDX_W-1:0] idx;
  } prio_t;

  function automatic int unsigned idx_width(input int unsigned lines);
    return (lines > 1) ? $clog2(lines) : 1;
  endfunction

  function automatic logic [31:0] none_code(input int unsigned dw);
    return (dw >= 32) ? '1 : ((32'd1 << dw) - 32'd1);
  endfunction

  // Ascending scan that latches only the first hit, so the lowest index wins.
  function automatic prio_t lowest_set(input logic [MAX_LINES-1:0] v);
    prio_t r;
    r = '0;
    for (int unsigned i = 0; i < MAX_LINES; i++) begin
      if (v[i] && !r.found) begin
        r.found = 1'b1;
        r.idx   = MAX_IDX_W'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/irq_synchronizer.sv
// irq_synchronizer: STAGES-deep flop chain per request line plus a "prev"
// register holding the previous synchronised value.
//   clk, rst  - clock, synchronous active-high reset
//   async_in  - asynchronous request lines
//   synced    - synchronised request level
//   rise      - synced & ~prev (one-cycle rising-edge pulse)
module irq_synchronizer #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] synced,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] chain [STAGES];
  logic [WIDTH-1:0] prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned s = 0; s < STAGES; s++) chain[s] <= '0;
      prev <= '0;
    end else begin
      chain[0] <= async_in;
      for (int unsigned s = 1; s < STAGES; s++) chain[s] <= chain[s-1];
      prev <= chain[STAGES-1];
    end
  end

  assign synced = chain[STAGES-1];
  assign rise   = synced & ~prev;

endmodule

// File: rtl/interrupt_priority_controller.sv
// interrupt_priority_controller: latches per-line pending requests (edge or
// level per line), applies a run-time mask and reports the lowest-index
// unmasked pending line. Software can create/dismiss/mask lines.
//   clk, rst        - clock, synchronous active-high reset
//   irq             - asynchronous request lines
//   create          - set pending for line data_in[DATA_WIDTH-2:0]
//   dismiss         - clear pending for that line (wins over create)
//   mask_write      - mask bit data_in[DATA_WIDTH-1] for that line
//   data_in         - command word
//   next_interrupt  - registered lowest unmasked pending index, else all ones
//   irq_active      - registered, next_interrupt != NONE
//   lost_count      - saturating count of edges lost on already-pending lines
module interrupt_priority_controller
  import intc_pkg::*;
#(
  parameter int unsigned      LINES       = 24,
  parameter int unsigned      DATA_WIDTH  = 12,
  parameter int unsigned      SYNC_STAGES = 2,
  parameter logic [LINES-1:0] EDGE_LINES  = '1,
  parameter logic [LINES-1:0] MASK_INIT   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LINES-1:0]      irq,
  input  logic                  create,
  input  logic                  dismiss,
  input  logic                  mask_write,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] next_interrupt,
  output logic                  irq_active,
  output logic [7:0]            lost_count
);

  localparam logic [DATA_WIDTH-1:0] NONE = DATA_WIDTH'(none_code(DATA_WIDTH));

  logic [LINES-1:0]      synced, rise;
  logic [LINES-1:0]      pending, pending_n;
  logic [LINES-1:0]      mask, mask_n;
  logic [7:0]            lost_n;
  logic [DATA_WIDTH-2:0] cmd_idx;
  logic                  cmd_valid;
  logic [LINES-1:0]      cmd_onehot;
  logic [LINES-1:0]      hw_set, dis_vec, cre_vec, lost_vec;
  int unsigned           lost_sum;
  prio_t                 prio;

  irq_synchronizer #(
    .WIDTH (LINES),
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .async_in(irq),
    .synced  (synced),
    .rise    (rise)
  );

  // All three commands share the index field; out-of-range indices decode to no line.
  assign cmd_idx    = data_in[DATA_WIDTH-2:0];
  assign cmd_valid  = (32'(cmd_idx) < LINES);
  assign cmd_onehot = cmd_valid ? (LINES'(1) << cmd_idx) : '0;

  always_comb begin
    hw_set  = (EDGE_LINES & rise) | (~EDGE_LINES & synced);
    dis_vec = dismiss ? cmd_onehot : '0;
    cre_vec = (create && !dismiss) ? cmd_onehot : '0;
    // Hardware set is OR'd last so it beats a same-cycle dismiss.
    pending_n = ((pending & ~dis_vec) | cre_vec) | hw_set;

    mask_n = mask;
    if (mask_write) begin
      mask_n = data_in[DATA_WIDTH-1] ? (mask | cmd_onehot) : (mask & ~cmd_onehot);
    end

    lost_vec = EDGE_LINES & rise & pending & ~dis_vec;
    lost_sum = 32'(lost_count);
    for (int unsigned i = 0; i < LINES; i++) lost_sum = lost_sum + 32'(lost_vec[i]);
    lost_n = (lost_sum > 255) ? 8'hFF : 8'(lost_sum);

    prio = lowest_set(MAX_LINES'(pending & ~mask));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending        <= '0;
      mask           <= MASK_INIT;
      lost_count     <= '0;
      next_interrupt <= NONE;
      irq_active     <= 1'b0;
    end else begin
      pending        <= pending_n;
      mask           <= mask_n;
      lost_count     <= lost_n;
      next_interrupt <= prio.found ? DATA_WIDTH'(prio.idx) : NONE;
      irq_active     <= prio.found;
    end
  end

endmodule

// File: tb/tb_interrupt_priority_controller.sv
// Directed bench for interrupt_priority_controller (line 0 level, others edge).
module tb_interrupt_priority_controller;

  localparam int unsigned LINES = 24;
  localparam int unsigned DW    = 12;

  logic             clk = 1'b0;
  logic             rst;
  logic [LINES-1:0] irq;
  logic             create, dismiss, mask_write;
  logic [DW-1:0]    data_in;
  logic [DW-1:0]    next_interrupt;
  logic             irq_active;
  logic [7:0]       lost_count;

  int checks   = 0;
  int failures = 0;

  interrupt_priority_controller #(
    .LINES      (LINES),
    .DATA_WIDTH (DW),
    .SYNC_STAGES(2),
    .EDGE_LINES (24'hFFFFFE),
    .MASK_INIT  (24'h000000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .irq           (irq),
    .create        (create),
    .dismiss       (dismiss),
    .mask_write    (mask_write),
    .data_in       (data_in),
    .next_interrupt(next_interrupt),
    .irq_active    (irq_active),
    .lost_count    (lost_count)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cmd(input logic c, input logic d, input logic m, input logic [DW-1:0] v);
    create = c; dismiss = d; mask_write = m; data_in = v;
    tick();
    create = 1'b0; dismiss = 1'b0; mask_write = 1'b0; data_in = '0;
  endtask

  initial begin
    rst = 1'b1; irq = '0; create = 1'b0; dismiss = 1'b0; mask_write = 1'b0; data_in = '0;
    tick(3);
    rst = 1'b0;
    check("reset_next", 32'(next_interrupt), 32'o7777);
    check("reset_active", 32'(irq_active), 0);
    check("reset_lost", 32'(lost_count), 0);

    // Edge on line 5, held 3 cycles: visible exactly 3 edges after first sample.
    irq[5] = 1'b1;
    tick(3);
    irq[5] = 1'b0;
    check("irq5_not_yet", 32'(next_interrupt), 32'o7777);
    tick();
    check("irq5_next", 32'(next_interrupt), 32'o0005);
    check("irq5_active", 32'(irq_active), 1);
    cmd(0, 1, 0, 12'o0005);
    tick();
    check("irq5_dismissed", 32'(next_interrupt), 32'o7777);

    // Pending {3,9}: priority and dismiss.
    cmd(1, 0, 0, 12'o0011);
    cmd(1, 0, 0, 12'o0003);
    tick();
    check("prio_3", 32'(next_interrupt), 32'o0003);
    cmd(0, 1, 0, 12'o0003);
    tick();
    check("prio_9", 32'(next_interrupt), 32'o0011);
    cmd(0, 1, 0, 12'o0011);
    tick();
    check("all_dismissed", 32'(next_interrupt), 32'o7777);
    check("all_dismissed_active", 32'(irq_active), 0);

    // Mask line 2, create it, then unmask.
    cmd(0, 0, 1, 12'o4002);
    cmd(1, 0, 0, 12'o0002);
    tick();
    check("masked_2", 32'(next_interrupt), 32'o7777);
    cmd(0, 0, 1, 12'o0002);
    check("unmask_latency", 32'(next_interrupt), 32'o7777);
    tick();
    check("unmasked_2", 32'(next_interrupt), 32'o0002);
    cmd(0, 1, 0, 12'o0002);
    tick();
    check("dismiss_2", 32'(next_interrupt), 32'o7777);

    // create + dismiss together: dismiss wins, create ignored.
    cmd(1, 1, 0, 12'o0004);
    tick();
    check("create_dismiss", 32'(next_interrupt), 32'o7777);

    // Level line 0: dismiss while high re-pends; after release dismiss clears.
    irq[0] = 1'b1;
    tick(4);
    check("level0", 32'(next_interrupt), 32'o0000);
    cmd(0, 1, 0, 12'o0000);
    tick();
    check("level0_repend", 32'(next_interrupt), 32'o0000);
    irq[0] = 1'b0;
    tick(3);
    cmd(0, 1, 0, 12'o0000);
    tick();
    check("level0_cleared", 32'(next_interrupt), 32'o7777);

    // Edge on line 6 collides with dismiss of line 6: set wins, nothing lost.
    irq[6] = 1'b1;
    tick(2);
    cmd(0, 1, 0, 12'o0006);
    tick();
    check("set_beats_dismiss", 32'(next_interrupt), 32'o0006);
    check("no_lost_yet", 32'(lost_count), 0);
    irq[6] = 1'b0;
    tick(3);
    cmd(0, 1, 0, 12'o0006);
    tick();
    check("dismiss_6", 32'(next_interrupt), 32'o7777);

    // Lost-request counting on pending line 7.
    cmd(1, 0, 0, 12'o0007);
    for (int i = 0; i < 10; i++) begin
      irq[7] = 1'b1; tick();
      irq[7] = 1'b0; tick();
    end
    tick(4);
    check("lost_10", 32'(lost_count), 10);
    for (int i = 0; i < 290; i++) begin
      irq[7] = 1'b1; tick();
      irq[7] = 1'b0; tick();
    end
    tick(4);
    check("lost_saturated", 32'(lost_count), 255);
    check("line7_pending", 32'(next_interrupt), 32'o0007);
    cmd(1, 0, 0, 12'o0030);
    tick();
    check("create_out_of_range", 32'(next_interrupt), 32'o0007);
    cmd(0, 1, 0, 12'o0007);
    tick();
    check("dismiss_7", 32'(next_interrupt), 32'o7777);

    // Reset during a pending burst with a request in the synchroniser.
    cmd(1, 0, 0, 12'o0010);
    cmd(1, 0, 0, 12'o0001);
    irq[12] = 1'b1;
    tick();
    irq[12] = 1'b0;
    check("burst_before_rst", 32'(next_interrupt), 32'o0001);
    rst = 1'b1;
    tick();
    check("midrst_next", 32'(next_interrupt), 32'o7777);
    check("midrst_active", 32'(irq_active), 0);
    check("midrst_lost", 32'(lost_count), 0);
    rst = 1'b0;
    tick(5);
    check("post_rst_clean", 32'(next_interrupt), 32'o7777);

    // irq held high through reset: one request after release.
    irq[15] = 1'b1;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(3);
    check("held_irq_latency", 32'(next_interrupt), 32'o7777);
    tick();
    check("held_irq_seen", 32'(next_interrupt), 32'o0017);
    cmd(0, 1, 0, 12'o0017);
    tick(4);
    check("held_irq_once", 32'(next_interrupt), 32'o7777);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
